// File: rtl/uart_tx_if.sv
// FIFO read handshake between the UART transmitter (master) and its upstream byte FIFO (slave).
interface uart_tx_if;
    logic       i_fifo_empty;
    logic       o_fifo_rd_en;
    logic [7:0] i_fifo_rd_data;
    logic       i_fifo_rd_valid;

    modport master (
        input  i_fifo_empty,
        output o_fifo_rd_en,
        input  i_fifo_rd_data,
        input  i_fifo_rd_valid
    );

    modport slave (
        output i_fifo_empty,
        input  o_fifo_rd_en,
        output i_fifo_rd_data,
        output i_fifo_rd_valid
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter that pops one byte at a time from an upstream FIFO.
// Frame: one start bit (0), eight data bits LSB first, one stop bit (1),
// each held for CLKS_PER_BIT clock cycles. All outputs are registered.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    uart_tx_if.master  fifo,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned    CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state;
    logic [CntW-1:0] baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            fetch_wait;   // set during the second FETCH cycle; timeout if no valid
    logic            tx;
    logic            busy;
    logic            done;
    logic            rd_en;

    assign o_tx              = tx;
    assign o_busy            = busy;
    assign o_done            = done;
    assign fifo.o_fifo_rd_en = rd_en;

    // Frame sequencer: state, baud/bit counters, shift register and all registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= StIdle;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            fetch_wait <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
        end else begin
            // Pop request and completion flag are single-cycle pulses.
            rd_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                StIdle: begin
                    baud_cnt <= '0;
                    if (!fifo.i_fifo_empty) begin
                        rd_en      <= 1'b1;
                        fetch_wait <= 1'b0;
                        busy       <= 1'b1;
                        state      <= StFetch;
                    end
                end
                StFetch: begin
                    if (fifo.i_fifo_rd_valid) begin
                        shift_reg <= fifo.i_fifo_rd_data;
                        tx        <= 1'b0;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        state     <= StStart;
                    end else if (fetch_wait) begin
                        // FIFO never answered; give up and retry from IDLE.
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        fetch_wait <= 1'b1;
                    end
                end
                StStart: begin
                    if (baud_cnt == CntMax) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift_reg[0];
                        state    <= StData;
                    end else begin
                        baud_cnt <= baud_cnt + CntW'(1);
                    end
                end
                StData: begin
                    if (baud_cnt == CntMax) begin
                        baud_cnt <= '0;
                        // 3-bit index wraps 7 -> 0 on the way into STOP.
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= StStop;
                        end else begin
                            tx <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CntW'(1);
                    end
                end
                StStop: begin
                    if (baud_cnt == CntMax) begin
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= StIdle;
                    end else begin
                        baud_cnt <= baud_cnt + CntW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with CLKS_PER_BIT=4 and a 1-cycle-latency FIFO model.
module tb_uart_tx;

    localparam int unsigned Cpb = 4;

    logic i_clk = 1'b0;
    logic i_rst;
    logic o_tx;
    logic o_busy;
    logic o_done;

    uart_tx_if fifo_bus ();

    uart_tx #(
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .fifo   (fifo_bus),
        .o_tx   (o_tx),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Bench state
    logic [7:0] fifo_q[$];
    bit         withhold = 1'b0;
    bit         spurious = 1'b0;
    bit         saw;

    int         n_checks = 0;
    int         n_pass   = 0;

    int         rd_cnt    = 0;
    int         done_cnt  = 0;
    int         busy_cnt  = 0;
    int         consec_rd = 0;
    int         frame_err = 0;
    bit         prev_rd   = 1'b0;
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte;
    logic [7:0] rx_q[$];
    int         high_run      = 0;
    int         last_high_run = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge i_clk);
            #2;
        end
    endtask

    task automatic wait_tx_low(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            if (o_tx === 1'b0) found = 1'b1;
            else tick(1);
        end
    endtask

    task automatic wait_rd_en(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            if (fifo_bus.o_fifo_rd_en === 1'b1) found = 1'b1;
            else tick(1);
        end
    endtask

    task automatic wait_rx(input int n, input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            if (rx_q.size() >= n) found = 1'b1;
            else tick(1);
        end
    endtask

    // FIFO model: a pop seen in cycle k returns data with valid during cycle k+1.
    initial begin
        fifo_bus.i_fifo_empty    = 1'b1;
        fifo_bus.i_fifo_rd_valid = 1'b0;
        fifo_bus.i_fifo_rd_data  = 8'h00;
        forever begin
            @(negedge i_clk);
            saw = fifo_bus.o_fifo_rd_en && !withhold;
            @(posedge i_clk);
            #1;
            fifo_bus.i_fifo_rd_valid = 1'b0;
            fifo_bus.i_fifo_rd_data  = 8'hA5;
            if (saw && fifo_q.size() > 0) begin
                fifo_bus.i_fifo_rd_valid = 1'b1;
                fifo_bus.i_fifo_rd_data  = fifo_q.pop_front();
            end else if (spurious) begin
                fifo_bus.i_fifo_rd_valid = 1'b1;
                fifo_bus.i_fifo_rd_data  = 8'h00;
            end
            fifo_bus.i_fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Line monitor: counts pulses and decodes 8N1 frames sampled mid-bit.
    always @(negedge i_clk) begin
        if (i_rst) begin
            rx_active = 1'b0;
            prev_rd   = 1'b0;
            high_run  = 0;
        end else begin
            if (fifo_bus.o_fifo_rd_en) begin
                rd_cnt++;
                if (prev_rd) consec_rd++;
            end
            prev_rd = fifo_bus.o_fifo_rd_en;
            if (o_done) done_cnt++;
            if (o_busy) busy_cnt++;
            if (!rx_active) begin
                if (o_tx == 1'b0) begin
                    rx_active     = 1'b1;
                    rx_cnt        = 0;
                    last_high_run = high_run;
                end else begin
                    high_run++;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
                    rx_byte[(rx_cnt - 6) / 4] = o_tx;
                if (rx_cnt == 38) begin
                    if (o_tx == 1'b1) rx_q.push_back(rx_byte);
                    else frame_err++;
                end
                if (rx_cnt == 39) begin
                    rx_active = 1'b0;
                    high_run  = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        int         viol;
        int         rd0, dn0, bz0;
        logic [9:0] pat;
        logic [39:0] cap, exp_cap;
        logic [7:0] b;

        // Reset with a byte already waiting: nothing may pop while reset is held.
        i_rst = 1'b1;
        fifo_q.push_back(8'h61);
        tick(3);
        check("rst_tx", o_tx, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_rd_en", fifo_bus.o_fifo_rd_en, 0);
        rd0 = rd_cnt; dn0 = done_cnt; bz0 = busy_cnt;
        i_rst = 1'b0;

        // Single byte 0x61: exact waveform, counters, decoded byte.
        wait_tx_low(20, found);
        check("t1_start_seen", found, 1);
        for (int i = 0; i < 40; i++) begin
            cap[i] = o_tx;
            tick(1);
        end
        pat = 10'b1011000010;  // time order bit0..bit9: 0,1,0,0,0,0,1,1,0,1
        for (int i = 0; i < 40; i++) exp_cap[i] = pat[i / 4];
        check("t1_waveform", cap, exp_cap);
        check("t1_done_pulse", o_done, 1);
        check("t1_busy_low", o_busy, 0);
        tick(5);
        check("t1_rd_pulses", rd_cnt - rd0, 1);
        check("t1_done_count", done_cnt - dn0, 1);
        check("t1_busy_cycles", busy_cnt - bz0, 42);
        check("t1_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            check("t1_rx_byte", b, 8'h61);
        end

        // Empty FIFO for 100 cycles: line idle, no pops.
        viol = 0;
        rd0 = rd_cnt;
        for (int i = 0; i < 100; i++) begin
            if (fifo_bus.o_fifo_rd_en !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) viol++;
            tick(1);
        end
        check("t2_idle_violations", viol, 0);
        check("t2_rd_pulses", rd_cnt - rd0, 0);

        // Back-to-back 0x41, 0x5A with a 3-cycle inter-frame gap.
        rd0 = rd_cnt; dn0 = done_cnt;
        fifo_q.push_back(8'h41);
        fifo_q.push_back(8'h5A);
        wait_rx(2, 300, found);
        check("t3_frames_seen", found, 1);
        tick(5);
        check("t3_rd_pulses", rd_cnt - rd0, 2);
        check("t3_done_count", done_cnt - dn0, 2);
        check("t3_gap", last_high_run, 3);
        if (rx_q.size() >= 2) begin
            b = rx_q.pop_front();
            check("t3_rx_first", b, 8'h41);
            b = rx_q.pop_front();
            check("t3_rx_second", b, 8'h5A);
        end else begin
            check("t3_rx_count", rx_q.size(), 2);
        end

        // FETCH timeout: valid withheld, return to IDLE, retry later.
        withhold = 1'b1;
        fifo_q.push_back(8'h33);
        wait_rd_en(20, found);
        check("t4_pop_seen", found, 1);
        check("t4_fetch1_busy", o_busy, 1);
        tick(1);
        check("t4_fetch2_busy", o_busy, 1);
        check("t4_fetch2_rd_en", fifo_bus.o_fifo_rd_en, 0);
        check("t4_fetch2_tx", o_tx, 1);
        tick(1);
        check("t4_idle_busy", o_busy, 0);
        check("t4_idle_tx", o_tx, 1);
        tick(1);
        check("t4_retry_rd_en", fifo_bus.o_fifo_rd_en, 1);
        withhold = 1'b0;
        wait_rx(1, 200, found);
        check("t4_frame_seen", found, 1);
        if (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            check("t4_rx_byte", b, 8'h33);
        end
        tick(3);

        // Reset during DATA bit 3 of 0xFF; next byte 0x3C must follow cleanly.
        dn0 = done_cnt;
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h3C);
        wait_tx_low(30, found);
        check("t5_start_seen", found, 1);
        tick(17);
        check("t5_busy_before_rst", o_busy, 1);
        i_rst = 1'b1;
        #1;
        check("t5_rst_tx", o_tx, 1);
        check("t5_rst_busy", o_busy, 0);
        check("t5_rst_done", o_done, 0);
        tick(3);
        check("t5_rst_rd_en", fifo_bus.o_fifo_rd_en, 0);
        i_rst = 1'b0;
        wait_rx(1, 200, found);
        check("t5_frame_seen", found, 1);
        tick(5);
        check("t5_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            check("t5_rx_byte", b, 8'h3C);
        end
        check("t5_done_count", done_cnt - dn0, 1);

        // Spurious valid with 0x00 during STOP is ignored.
        rd0 = rd_cnt; dn0 = done_cnt;
        fifo_q.push_back(8'h55);
        wait_tx_low(30, found);
        check("t6_start_seen", found, 1);
        tick(36);
        check("t6_stop_tx", o_tx, 1);
        spurious = 1'b1;
        tick(2);
        spurious = 1'b0;
        tick(30);
        check("t6_rd_pulses", rd_cnt - rd0, 1);
        check("t6_done_count", done_cnt - dn0, 1);
        check("t6_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            check("t6_rx_byte", b, 8'h55);
        end
        check("t6_busy_low", o_busy, 0);

        check("consecutive_rd_en", consec_rd, 0);
        check("frame_errors", frame_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
